jumbo_pattern_checker: RTL and testbench

JUMBO_PATTERN_CHECKER -- requirements
Module: jumbo_pattern_checker

---
 rtl/jumbo_pattern_checker.sv | 165 ++++++++++++++++
 tb/tb_jumbo_pattern_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jumbo_pattern_checker.sv
// jumbo_pattern_checker: checks indexed test-pattern Ethernet frames and keeps good/error/gap statistics.
// Define CHECKER_LATENCY_EN to build the one-way latency measurement from the embedded TX timestamp.
module jumbo_pattern_checker #(
    parameter int unsigned DATA_LENGTH = 7000,
    parameter logic [47:0] LOCAL_MAC   = 48'h07_08_09_0a_0b_0c,
    parameter logic [15:0] ETH_TYPE    = 16'h88B5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] timestamp,
    input  logic        s_eth_hdr_valid,
    output logic        s_eth_hdr_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [7:0]  s_eth_payload_axis_tdata,
    input  logic        s_eth_payload_axis_tvalid,
    input  logic        s_eth_payload_axis_tlast,
    input  logic        s_eth_payload_axis_tuser,
    output logic        s_eth_payload_axis_tready,
    output logic [31:0] good_count,
    output logic [31:0] err_count,
    output logic [31:0] gap_count,
    output logic [3:0]  err_flags,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] latency_us,
    output logic [15:0] latency_max
);
    typedef enum logic [1:0] {IDLE, INFO, DATA, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, idx_q, idx_d, exp_idx_q;
    logic [31:0] good_q, err_q, gap_q;
    logic [7:0]  exp_q;
    logic [3:0]  flags_q;
    logic        first_q, derr_q, derr_d, done_q, ok_q;
    logic        beat, hdr_fire, hdr_match, checked, frame_end;
    logic        byte_err, len_err, tu_err, ok, gap;
    logic        unused_src;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign beat      = s_eth_payload_axis_tvalid;
    assign hdr_fire  = s_eth_hdr_valid && s_eth_hdr_ready;
    assign hdr_match = enable && s_eth_dest_mac == LOCAL_MAC && s_eth_type == ETH_TYPE;
    assign checked   = state_q == INFO || state_q == DATA;
    assign frame_end = beat && s_eth_payload_axis_tlast && checked;
    assign idx_d     = (state_q == INFO && cnt_q < 32'd4) ? {idx_q[23:0], s_eth_payload_axis_tdata} : idx_q;
    assign byte_err  = state_q == DATA && cnt_q < DATA_LENGTH && s_eth_payload_axis_tdata != exp_q;
    assign derr_d    = derr_q | (beat && byte_err);
    assign len_err   = cnt_q != DATA_LENGTH - 1;
    assign tu_err    = s_eth_payload_axis_tuser;
    assign ok        = !(derr_d || len_err || tu_err);
    assign gap       = !first_q && idx_d != exp_idx_q;
    assign unused_src = ^s_eth_src_mac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hdr_fire) state_d = hdr_match ? INFO : DROP;
            INFO:    if (beat) state_d = s_eth_payload_axis_tlast ? IDLE : (cnt_q == 32'd7 ? DATA : INFO);
            default: if (beat && s_eth_payload_axis_tlast) state_d = IDLE;
        endcase
    end

    always_comb begin
        s_eth_hdr_ready           = state_q == IDLE;
        s_eth_payload_axis_tready = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            exp_idx_q <= '0;
            exp_q     <= '0;
            derr_q    <= 1'b0;
            first_q   <= 1'b1;
            good_q    <= '0;
            err_q     <= '0;
            gap_q     <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (frame_end) ok_q <= ok;
            if (hdr_fire) begin
                cnt_q  <= '0;
                derr_q <= 1'b0;
            end else if (beat && checked) begin
                cnt_q  <= sat_inc(cnt_q);
                idx_q  <= idx_d;
                derr_q <= derr_d;
                // byte 3 is the index LSB, which seeds the running data pattern
                if (state_q == INFO && cnt_q == 32'd3) exp_q <= s_eth_payload_axis_tdata;
                else if (state_q == DATA)              exp_q <= exp_q + 8'd1;
            end
            if (clear) begin
                good_q  <= '0;
                err_q   <= '0;
                gap_q   <= '0;
                flags_q <= '0;
                first_q <= 1'b1;
            end else if (frame_end) begin
                good_q    <= ok ? sat_inc(good_q) : good_q;
                err_q     <= ok ? err_q : sat_inc(err_q);
                gap_q     <= gap ? sat_inc(gap_q) : gap_q;
                flags_q   <= flags_q | {tu_err, len_err, derr_d, gap};
                first_q   <= 1'b0;
                exp_idx_q <= idx_d + 32'd1;
            end
        end
    end

    assign good_count = good_q;
    assign err_count  = err_q;
    assign gap_count  = gap_q;
    assign err_flags  = flags_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;

`ifdef CHECKER_LATENCY_EN
    logic [15:0] ts_q, lat_q, lmax_q, lat_d;

    assign lat_d = timestamp - ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            lat_q  <= '0;
            lmax_q <= '0;
        end else begin
            if (beat && state_q == INFO && cnt_q == 32'd4) ts_q[15:8] <= s_eth_payload_axis_tdata;
            if (beat && state_q == INFO && cnt_q == 32'd5) ts_q[7:0]  <= s_eth_payload_axis_tdata;
            if (clear) begin
                lat_q  <= '0;
                lmax_q <= '0;
            end else if (frame_end && ok) begin
                lat_q  <= lat_d;
                lmax_q <= (lat_d > lmax_q) ? lat_d : lmax_q;
            end
        end
    end

    assign latency_us  = lat_q;
    assign latency_max = lmax_q;
`else
    logic unused_ts;

    assign unused_ts   = ^timestamp;
    assign latency_us  = '0;
    assign latency_max = '0;
`endif
endmodule

// File: tb/tb_jumbo_pattern_checker.sv
// tb_jumbo_pattern_checker: directed and randomized frames checked against a frame-level reference model.
module tb_jumbo_pattern_checker;
    localparam int          DL    = 200;
    localparam logic [47:0] LMAC  = 48'h07_08_09_0a_0b_0c;
    localparam logic [47:0] OMAC  = 48'h01_02_03_04_05_06;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic        clk = 0, rst_n = 0, enable = 0, clear = 0;
    logic [15:0] timestamp = 0;
    logic        hdr_valid = 0, hdr_ready;
    logic [47:0] dmac = 0, smac = 0;
    logic [15:0] typ = 0;
    logic [7:0]  tdata = 0;
    logic        tvalid = 0, tlast = 0, tuser = 0, tready;
    logic [31:0] good_count, err_count, gap_count;
    logic [3:0]  err_flags;
    logic        frame_done, frame_ok;
    logic [15:0] latency_us, latency_max;

    int checks = 0, errors = 0;

    int unsigned m_good, m_err, m_gap;
    logic [3:0]  m_flags;
    bit          m_first;
    logic [31:0] m_exp;
    logic [15:0] m_lat, m_lmax;

    jumbo_pattern_checker #(.DATA_LENGTH(DL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .timestamp(timestamp),
        .s_eth_hdr_valid(hdr_valid), .s_eth_hdr_ready(hdr_ready),
        .s_eth_dest_mac(dmac), .s_eth_src_mac(smac), .s_eth_type(typ),
        .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tvalid(tvalid),
        .s_eth_payload_axis_tlast(tlast), .s_eth_payload_axis_tuser(tuser),
        .s_eth_payload_axis_tready(tready),
        .good_count(good_count), .err_count(err_count), .gap_count(gap_count),
        .err_flags(err_flags), .frame_done(frame_done), .frame_ok(frame_ok),
        .latency_us(latency_us), .latency_max(latency_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_good = 0; m_err = 0; m_gap = 0; m_flags = 0;
        m_first = 1; m_exp = 0; m_lat = 0; m_lmax = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".good"}, good_count, m_good);
        check({tag, ".err"}, err_count, m_err);
        check({tag, ".gap"}, gap_count, m_gap);
        check({tag, ".flags"}, {28'd0, err_flags}, {28'd0, m_flags});
        check({tag, ".lat"}, {16'd0, latency_us}, {16'd0, m_lat});
        check({tag, ".lmax"}, {16'd0, latency_max}, {16'd0, m_lmax});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".good"}, good_count, 0);
        check({tag, ".err"}, err_count, 0);
        check({tag, ".gap"}, gap_count, 0);
        check({tag, ".flags"}, {28'd0, err_flags}, 0);
        check({tag, ".done_ok"}, {30'd0, frame_done, frame_ok}, 0);
        check({tag, ".lat"}, {latency_us, latency_max}, 0);
        check({tag, ".ready"}, {30'd0, hdr_ready, tready}, 3);
    endtask

    task automatic clear_all(input string tag);
        @(negedge clk); clear = 1;
        @(negedge clk); clear = 0;
        model_reset();
        check_state(tag);
    endtask

    task automatic send_frame(input logic [47:0] dm, input logic [15:0] ty, input logic en,
                              input logic [31:0] idx, input int len, input int corrupt,
                              input logic tu, input logic [15:0] txts, input logic [15:0] arrts,
                              input int rst_at, input bit clr_last, input string tag);
        logic [7:0] b;
        bit was_reset, chk, derr, ok, gap;
        was_reset = 0;
        chk = en && dm == LMAC && ty == ETYPE;
        @(negedge clk);
        check({tag, ".hdr_ready"}, {31'd0, hdr_ready}, 1);
        dmac = dm; typ = ty; smac = 48'({$urandom, $urandom}); enable = en;
        hdr_valid = 1; timestamp = arrts;
        @(negedge clk);
        hdr_valid = 0; enable = 1'($urandom);
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                tvalid = 0;
                #2 rst_n = 0;
                #1 check_reset_outputs({tag, ".rst"});
                @(negedge clk);
                rst_n = 1;
                model_reset();
                was_reset = 1;
            end
            if ($urandom_range(0, 7) == 0) begin
                tvalid = 0;
                @(negedge clk);
            end
            if (i < 4)       b = 8'(idx >> (8 * (3 - i)));
            else if (i == 4) b = txts[15:8];
            else if (i == 5) b = txts[7:0];
            else if (i < 8)  b = 8'($urandom);
            else             b = 8'(idx[7:0] + 8'(i - 8));
            if (i == corrupt) b = b ^ 8'h5A;
            tdata = b; tvalid = 1; tlast = (i == len - 1);
            tuser = tu && (i == len - 1); clear = clr_last && (i == len - 1);
            @(negedge clk);
        end
        tvalid = 0; tlast = 0; tuser = 0; clear = 0;
        chk = chk && !was_reset;
        derr = corrupt >= 8 && corrupt < len && corrupt < DL;
        ok = len == DL && !derr && !tu;
        if (!clr_last) begin
            check({tag, ".done"}, {31'd0, frame_done}, {31'd0, chk});
            if (chk) check({tag, ".ok"}, {31'd0, frame_ok}, {31'd0, ok});
        end
        check({tag, ".idle"}, {31'd0, hdr_ready}, 1);
        if (clr_last) model_reset();
        else if (chk) begin
            gap = !m_first && idx != m_exp;
            if (ok) m_good++; else m_err++;
            if (gap) m_gap++;
            m_flags = m_flags | {tu, len != DL, derr, gap};
            m_exp = idx + 1;
            m_first = 0;
`ifdef CHECKER_LATENCY_EN
            if (ok) begin
                m_lat = arrts - txts;
                if (m_lat > m_lmax) m_lmax = m_lat;
            end
`endif
        end
        check_state(tag);
    endtask

    initial begin
        logic [31:0] ridx;
        int rlen, rcor;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;

        for (int k = 5; k <= 7; k++) send_frame(LMAC, ETYPE, 1, k, DL, -1, 0, 16'h1000, 16'h1005, -1, 0, "seq567");
        check("seq567.good3", good_count, 3);

        clear_all("clr1");
        send_frame(LMAC, ETYPE, 1, 10, DL, 108, 0, 16'h0, 16'h0, -1, 0, "corrupt");
        check("corrupt.derr", {31'd0, err_flags[1]}, 1);

        clear_all("clr2");
        send_frame(LMAC, ETYPE, 1, 1, DL, -1, 0, 16'h0, 16'h3, -1, 0, "gap1");
        send_frame(LMAC, ETYPE, 1, 2, DL, -1, 0, 16'h0, 16'h3, -1, 0, "gap2");
        send_frame(LMAC, ETYPE, 1, 4, DL, -1, 0, 16'h0, 16'h3, -1, 0, "gap4");
        check("gap.count", gap_count, 1);

        clear_all("clr3");
        send_frame(LMAC, ETYPE, 1, 1, DL - 1, -1, 0, 16'h0, 16'h0, -1, 0, "short");
        send_frame(LMAC, ETYPE, 1, 2, DL + 1, -1, 0, 16'h0, 16'h0, -1, 0, "long");
        check("len.err2", err_count, 2);

        send_frame(OMAC, ETYPE, 1, 3, DL, -1, 0, 16'h0, 16'h0, -1, 0, "dropmac");
        send_frame(LMAC, 16'h0800, 1, 3, DL, -1, 0, 16'h0, 16'h0, -1, 0, "droptype");
        send_frame(LMAC, ETYPE, 0, 3, DL, -1, 0, 16'h0, 16'h0, -1, 0, "dropen");

        clear_all("clr4");
        send_frame(LMAC, ETYPE, 1, 20, DL, -1, 0, 16'hFFF0, 16'h0010, -1, 0, "lat");
        send_frame(LMAC, ETYPE, 1, 21, DL, -1, 0, 16'h0100, 16'h0105, -1, 0, "latlow");
        send_frame(LMAC, ETYPE, 1, 32'hFFFF_FFFF, DL, -1, 0, 16'h0, 16'h0, -1, 0, "wrap_hi");
        send_frame(LMAC, ETYPE, 1, 0, DL, -1, 0, 16'h0, 16'h0, -1, 0, "wrap_lo");
        send_frame(LMAC, ETYPE, 1, 1, DL, -1, 1, 16'h0, 16'h0, -1, 0, "tuser");
        send_frame(LMAC, ETYPE, 1, 2, DL, -1, 0, 16'h0, 16'h0, -1, 1, "clrlast");
        send_frame(LMAC, ETYPE, 1, 90, DL, -1, 0, 16'h0, 16'h0, -1, 0, "afterclr");

        send_frame(LMAC, ETYPE, 1, 40, DL, -1, 0, 16'h0, 16'h0, 150, 0, "midrst");
        send_frame(LMAC, ETYPE, 1, 77, DL, -1, 0, 16'h0, 16'h0, -1, 0, "postrst");
        check("postrst.good1", good_count, 1);

        ridx = $urandom;
        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 5))
                0:       rlen = DL - 1;
                1:       rlen = DL + 1;
                2:       rlen = 6;
                default: rlen = DL;
            endcase
            rcor = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, DL - 1)) : -1;
            send_frame(($urandom_range(0, 6) == 0) ? OMAC : LMAC, ETYPE, $urandom_range(0, 6) != 0,
                       ridx, rlen, rcor, $urandom_range(0, 5) == 0, 16'($urandom), 16'($urandom),
                       -1, 0, "rand");
            ridx = ($urandom_range(0, 4) == 0) ? $urandom : ridx + 1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
